// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder/subtractor. A single 16-bit ripple slice is reused
// once per chunk, LSB first, behind valid/ready handshakes on both sides.

module wide_add_slice16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        c_i,
  output logic [15:0] s_o,
  output logic        c_o
);
  logic [16:0] total;

  assign total = {1'b0, a_i} + {1'b0, b_i} + {16'd0, c_i};
  assign s_o   = total[15:0];
  assign c_o   = total[16];
endmodule

module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] sum,
  output logic                cout,
  output logic                ovf
);
  localparam int N    = 16 * WORDS;
  localparam int IDXW = $clog2(WORDS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [15:0]     a_cur, b_cur, slice_s;
  logic            slice_c;
  logic            accept;
  logic [WORDS-1:0] chunk_we;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // Select the operand chunks addressed by the current index.
  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_cur = a_q[i*16 +: 16];
        b_cur = b_q[i*16 +: 16];
      end
    end
  end

  wide_add_slice16 u_slice (
    .a_i (a_cur),
    .b_i (b_cur),
    .c_i (carry_q),
    .s_o (slice_s),
    .c_o (slice_c)
  );

  // Only the chunk under the index is rewritten; the rest hold their value.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_chunk
    assign chunk_we[gi] = (state_q == RUN) && (idx_q == IDXW'(gi));
    assign sum_d[gi*16 +: 16] = chunk_we[gi] ? slice_s : sum_q[gi*16 +: 16];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = a;
          b_d     = b ^ {N{sub}};
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = slice_c;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_c;
          // Operand signs agree but the result sign differs.
          ovf_d   = (a_cur[15] == b_cur[15]) && (slice_s[15] != a_cur[15]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Randomised plus directed bench for wide_add_sequencer (WORDS=4), checked
// against an arithmetic reference model.

module tb_wide_add_sequencer;
  localparam int WORDS = 4;
  localparam int N     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_vec = 0;
  int n_err = 0;

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the full-width values.
  task automatic ref_model(input logic [63:0] ra, input logic [63:0] rb, input logic rc,
                           input logic rs, output logic [63:0] es, output logic ec,
                           output logic eo);
    logic [64:0]        ufull;
    logic signed [65:0] sfull;
    if (rs) begin
      es    = ra - rb;
      ec    = (ra >= rb);
      sfull = $signed({{2{ra[63]}}, ra}) - $signed({{2{rb[63]}}, rb});
    end else begin
      ufull = {1'b0, ra} + {1'b0, rb} + {64'd0, rc};
      es    = ufull[63:0];
      ec    = ufull[64];
      sfull = $signed({{2{ra[63]}}, ra}) + $signed({{2{rb[63]}}, rb}) + $signed({65'd0, rc});
    end
    eo = !((sfull[65:63] == 3'b000) || (sfull[65:63] == 3'b111));
  endtask

  // Present an operation and return right after the accepting edge.
  task automatic start_op(input logic [63:0] ta, input logic [63:0] tb, input logic tc,
                          input logic ts);
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    #1 check_val("in_ready_idle", in_ready, 1);
    @(posedge clk);
  endtask

  // Wait for DONE, checking latency, busy handshake and the result.
  task automatic wait_result(input logic [63:0] es, input logic ec, input logic eo);
    int lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    while (!out_valid && lat < 20) begin
      check_val("in_ready_busy", in_ready, 0);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    out_ready = 1'b0;
    check_val("latency", lat, WORDS);
    check_val("sum", sum, es);
    check_val("cout", cout, ec);
    check_val("ovf", ovf, eo);
  endtask

  task automatic release_result(input logic [63:0] es, input int hold);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_val("hold_valid", out_valid, 1);
      check_val("hold_sum", sum, es);
      check_val("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check_val("consumed_valid", out_valid, 0);
    check_val("idle_in_ready", in_ready, 1);
    check_val("idle_sum_kept", sum, es);
  endtask

  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb, input logic tc,
                        input logic ts, input logic [63:0] es, input logic ec,
                        input logic eo, input int hold);
    start_op(ta, tb, tc, ts);
    wait_result(es, ec, eo);
    release_result(es, hold);
  endtask

  initial begin
    logic [63:0] ra, rb, es, es2;
    logic        rc, rs, ec, eo, ec2, eo2;
    int          seen;

    // Reset held for two edges.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_sum", sum, 0);
    check_val("rst_cout", cout, 0);
    check_val("rst_ovf", ovf, 0);
    check_val("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1 check_val("post_rst_in_ready", in_ready, 1);

    // Directed cases.
    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1);
    run_op(64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 0);
    run_op(64'h7, 64'h5, 1'b1, 1'b1, 64'h2, 1'b1, 1'b0, 0);
    ra = {$urandom, $urandom};
    run_op(ra, ra, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0, 2);

    // Backpressure: new operands offered while DONE is stalled.
    start_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
    ref_model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, es, ec, eo);
    wait_result(es, ec, eo);
    ra = 64'h8000_0000_0000_0001;
    rb = 64'h0000_0000_0000_0002;
    ref_model(ra, rb, 1'b0, 1'b1, es2, ec2, eo2);
    a = ra; b = rb; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      check_val("bp_valid", out_valid, 1);
      check_val("bp_sum", sum, es);
      check_val("bp_cout", cout, ec);
      check_val("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1 check_val("bp_idle_in_ready", in_ready, 1);
    @(posedge clk);
    wait_result(es2, ec2, eo2);
    release_result(es2, 0);

    // Abort with reset on the second RUN cycle.
    ra = 64'h1111_2222_3333_4444;
    rb = 64'h0101_0202_0303_0404;
    start_op(ra, rb, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_val("partial_chunk0", sum[15:0], 16'h4848);
    rst = 1'b1;
    @(negedge clk);
    check_val("abort_out_valid", out_valid, 0);
    check_val("abort_sum", sum, 0);
    check_val("abort_cout", cout, 0);
    check_val("abort_ovf", ovf, 0);
    check_val("abort_in_ready", in_ready, 0);
    rst = 1'b0;
    #1 check_val("abort_idle", in_ready, 1);
    seen = 0;
    for (int h = 0; h < 8; h++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_val("abort_no_valid", seen, 0);

    // Reset and in_valid together: nothing is accepted.
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    rst = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1 check_val("rst_beats_valid", in_ready, 1);

    // Randomised operations against the model.
    for (int k = 0; k < 40; k++) begin
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) ra[63:16] = {48{ra[63]}};
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      ref_model(ra, rb, rc, rs, es, ec, eo);
      run_op(ra, rb, rc, rs, es, ec, eo, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
